// File: rtl/c_fetch_responder.sv
// c_fetch_responder: turns halfword-aligned fetch requests into word-aligned req/gnt/rvalid memory reads.
// Optional 1-entry line buffer enabled by defining C_FETCH_LINE_BUF_EN.
module c_fetch_responder #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_req,
    input  logic              icache_req_kill,
    input  logic              icache_flush,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic              icache_valid,
    output logic [31:0]       icache_inst,
    output logic              icache_busy,
    output logic              lb_hit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n, pend_addr, pend_addr_n;
    logic pend_v, pend_v_n;
    logic kill, direct, deliver, lb_serve, lb_take;
    logic [31:0] lb_word;
    assign kill = icache_req_kill | icache_flush;
    // A kill in REQ before the grant lets a same-cycle request reissue immediately.
    assign direct = (state == REQ) && kill && !mem_gnt;
`ifdef C_FETCH_LINE_BUF_EN
    logic              lb_valid;
    logic [ADDR_W-3:0] lb_tag;
    logic [31:0]       lb_data;
    assign lb_take = lb_valid && !icache_flush && (lb_tag == icache_addr[ADDR_W-1:2]);
    assign lb_word = lb_data;
    // Line buffer captures every delivered word; flush wins over a same-cycle fill.
    always_ff @(posedge clk) begin
        if (reset) lb_valid <= 1'b0;
        else if (icache_flush) lb_valid <= 1'b0;
        else if (deliver) begin
            lb_valid <= 1'b1;
            lb_tag   <= addr_q[ADDR_W-1:2];
            lb_data  <= mem_rdata;
        end
    end
`else
    assign lb_take = 1'b0;
    assign lb_word = '0;
`endif
    // State, latched address and pending slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            pend_v    <= pend_v_n;
            pend_addr <= pend_addr_n;
        end
    end
    // Next-state, next address and pending-slot update.
    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        pend_v_n    = pend_v;
        pend_addr_n = pend_addr;
        deliver     = 1'b0;
        lb_serve    = 1'b0;
        case (state)
            IDLE: begin
                if (icache_req && (kill || !pend_v)) begin
                    pend_v_n = 1'b0;
                    if (lb_take) lb_serve = 1'b1;
                    else begin
                        state_n = REQ;
                        addr_n  = icache_addr;
                    end
                end else if (pend_v && !kill) begin
                    state_n     = REQ;
                    addr_n      = pend_addr;
                    pend_v_n    = icache_req;
                    pend_addr_n = icache_addr;
                end else if (kill) pend_v_n = 1'b0;
            end
            REQ: begin
                if (direct) begin
                    pend_v_n = 1'b0;
                    state_n  = icache_req ? REQ : IDLE;
                    addr_n   = icache_req ? icache_addr : addr_q;
                end else if (mem_gnt) state_n = kill ? DRAIN : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_n = IDLE;
                    deliver = !kill;
                end else if (kill) state_n = DRAIN;
            end
            DRAIN: state_n = mem_rvalid ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
        if (state != IDLE && !direct) begin
            if (icache_req) begin
                pend_v_n    = 1'b1;
                pend_addr_n = icache_addr;
            end else if (kill) pend_v_n = 1'b0;
        end
    end
    // Registered response: one-cycle valid pulse, instruction word held between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            icache_valid <= 1'b0;
            icache_inst  <= '0;
            lb_hit       <= 1'b0;
        end else begin
            icache_valid <= deliver | lb_serve;
            lb_hit       <= lb_serve;
            icache_inst  <= deliver ? mem_rdata : lb_serve ? lb_word : icache_inst;
        end
    end
    // State-decoded memory and status outputs.
    always_comb begin
        mem_req     = (state == REQ);
        mem_addr    = addr_q & ~ADDR_W'(3);
        icache_busy = (state != IDLE);
    end
endmodule

// File: tb/tb_c_fetch_responder.sv
// tb_c_fetch_responder: directed self-checking bench for c_fetch_responder.
module tb_c_fetch_responder;
    logic        clk = 1'b0;
    logic        reset, icache_req, icache_req_kill, icache_flush;
    logic [31:0] icache_addr;
    logic        icache_valid, icache_busy, lb_hit, mem_req;
    logic [31:0] icache_inst, mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    int checks = 0;
    int errors = 0;

    c_fetch_responder #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .icache_req(icache_req), .icache_req_kill(icache_req_kill),
        .icache_flush(icache_flush), .icache_addr(icache_addr), .icache_valid(icache_valid),
        .icache_inst(icache_inst), .icache_busy(icache_busy), .lb_hit(lb_hit), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pulse();
        icache_flush = 1'b1;
        step();
        icache_flush = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input string tag);
        icache_req = 1'b1; icache_addr = a;
        step();
        icache_req = 1'b0;
        check({tag, "_mreq"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_maddr"}, mem_addr, a & ~32'd3);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d;
        step();
        mem_rvalid = 1'b0;
        check({tag, "_valid"}, {31'd0, icache_valid}, 32'd1);
        check({tag, "_inst"}, icache_inst, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; icache_req = 1'b0; icache_req_kill = 1'b0; icache_flush = 1'b0;
        icache_addr = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        reset = 1'b0;
        check("rst_valid", {31'd0, icache_valid}, 32'd0);
        check("rst_inst", icache_inst, 32'd0);
        check("rst_mreq", {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, icache_busy}, 32'd0);
        check("rst_lbhit", {31'd0, lb_hit}, 32'd0);
        // 1: basic fetch, gnt after one cycle, rvalid two cycles after gnt
        icache_req = 1'b1; icache_addr = 32'h100;
        step();
        icache_req = 1'b0;
        check("t1_mreq", {31'd0, mem_req}, 32'd1);
        check("t1_maddr", mem_addr, 32'h100);
        check("t1_busy", {31'd0, icache_busy}, 32'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("t1_wait_mreq", {31'd0, mem_req}, 32'd0);
        step();
        check("t1_no_early", {31'd0, icache_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_rvalid = 1'b0;
        check("t1_valid", {31'd0, icache_valid}, 32'd1);
        check("t1_inst", icache_inst, 32'hDEADBEEF);
        check("t1_idle", {31'd0, icache_busy}, 32'd0);
        step();
        check("t1_pulse", {31'd0, icache_valid}, 32'd0);
        check("t1_hold", icache_inst, 32'hDEADBEEF);
        // 2: halfword address maps to the containing word
        flush_pulse();
        fetch(32'h102, 32'hCAFEF00D, "t2");
        step();
        // 3: kill+req in WAIT; old data discarded, new request served from the pending slot
        flush_pulse();
        icache_req = 1'b1; icache_addr = 32'h100;
        step();
        icache_req = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; icache_req_kill = 1'b1; icache_req = 1'b1; icache_addr = 32'h104;
        step();
        icache_req_kill = 1'b0; icache_req = 1'b0;
        check("t3_drain_busy", {31'd0, icache_busy}, 32'd1);
        check("t3_drain_mreq", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        step();
        mem_rvalid = 1'b0;
        check("t3_discard", {31'd0, icache_valid}, 32'd0);
        step();
        check("t3_pend_mreq", {31'd0, mem_req}, 32'd1);
        check("t3_pend_maddr", mem_addr, 32'h104);
        check("t3_no_valid", {31'd0, icache_valid}, 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
        step();
        mem_rvalid = 1'b0;
        check("t3_valid", {31'd0, icache_valid}, 32'd1);
        check("t3_inst", icache_inst, 32'h22222222);
        step();
        check("t3_single", {31'd0, icache_valid}, 32'd0);
        // 3b: kill in the same cycle as rvalid discards the word
        flush_pulse();
        icache_req = 1'b1; icache_addr = 32'h108;
        step();
        icache_req = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; icache_req_kill = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
        step();
        icache_req_kill = 1'b0; mem_rvalid = 1'b0;
        check("t3b_valid", {31'd0, icache_valid}, 32'd0);
        check("t3b_busy", {31'd0, icache_busy}, 32'd0);
        check("t3b_inst", icache_inst, 32'h22222222);
        step();
        check("t3b_no_reissue", {31'd0, mem_req}, 32'd0);
        // 4: request while busy is served in order after the first
        flush_pulse();
        icache_req = 1'b1; icache_addr = 32'h200;
        step();
        icache_addr = 32'h204; mem_gnt = 1'b1;
        step();
        icache_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA0200;
        step();
        mem_rvalid = 1'b0;
        check("t4_first_valid", {31'd0, icache_valid}, 32'd1);
        check("t4_first_inst", icache_inst, 32'hAAAA0200);
        step();
        check("t4_busy", {31'd0, icache_busy}, 32'd1);
        check("t4_maddr", mem_addr, 32'h204);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBBBB0204;
        step();
        mem_rvalid = 1'b0;
        check("t4_second_valid", {31'd0, icache_valid}, 32'd1);
        check("t4_second_inst", icache_inst, 32'hBBBB0204);
        // 4b: kill+req in REQ before grant reissues directly with the new address
        flush_pulse();
        icache_req = 1'b1; icache_addr = 32'h300;
        step();
        icache_req_kill = 1'b1; icache_addr = 32'h304;
        step();
        icache_req_kill = 1'b0; icache_req = 1'b0;
        check("t4b_mreq", {31'd0, mem_req}, 32'd1);
        check("t4b_maddr", mem_addr, 32'h304);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h33333333;
        step();
        mem_rvalid = 1'b0;
        check("t4b_inst", icache_inst, 32'h33333333);
        step();
        // 5: line buffer
        flush_pulse();
        fetch(32'h200, 32'h5555AAAA, "t5");
        step();
        icache_req = 1'b1; icache_addr = 32'h202;
        step();
        icache_req = 1'b0;
`ifdef C_FETCH_LINE_BUF_EN
        check("t5_hit_valid", {31'd0, icache_valid}, 32'd1);
        check("t5_hit_lb", {31'd0, lb_hit}, 32'd1);
        check("t5_hit_inst", icache_inst, 32'h5555AAAA);
        check("t5_hit_mreq", {31'd0, mem_req}, 32'd0);
        step();
        check("t5_hit_pulse", {31'd0, lb_hit}, 32'd0);
        flush_pulse();
        icache_req = 1'b1; icache_addr = 32'h200;
        step();
        icache_req = 1'b0;
        check("t5_flush_mreq", {31'd0, mem_req}, 32'd1);
        check("t5_flush_lb", {31'd0, lb_hit}, 32'd0);
`else
        check("t5_nolb_mreq", {31'd0, mem_req}, 32'd1);
        check("t5_nolb_lb", {31'd0, lb_hit}, 32'd0);
`endif
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
        step();
        mem_rvalid = 1'b0;
        check("t5_mem_lb", {31'd0, lb_hit}, 32'd0);
        step();
        // 6: reset during WAIT, stale rvalid afterwards is ignored
        flush_pulse();
        icache_req = 1'b1; icache_addr = 32'h400;
        step();
        icache_req = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h66666666;
        step();
        mem_rvalid = 1'b0;
        check("t6_valid", {31'd0, icache_valid}, 32'd0);
        check("t6_busy", {31'd0, icache_busy}, 32'd0);
        check("t6_mreq", {31'd0, mem_req}, 32'd0);
        step();
        check("t6_valid_late", {31'd0, icache_valid}, 32'd0);
        check("t6_inst", icache_inst, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
